// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from four byte channels.
// One frame in flight at a time, with a sticky watchdog error for hung frames.
module uart_tx_arbiter #(
  parameter logic [15:0] TMO_CYCLES = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        tx_start,
  output logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    LAUNCH    = 4'b0010,
    WAIT_DONE = 4'b0100,
    GAP       = 4'b1000
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        armed_r;
  logic        tx_active_d_r;
  logic [15:0] wdog_r;
  logic [1:0]  grant_r;
  logic [7:0]  tx_data_r;
  logic [3:0]  req_ready_r;
  logic        tx_start_r;
  logic        busy_r;
  logic        timeout_err_r;
  logic        grant_go_s;
  logic        tmo_hit_s;
  logic [1:0]  winner_s;

  // Lowest offset from last+1 wins, so scan offsets high to low and keep the last hit.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] valid);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 3; i >= 0; i--) begin
      idx     = last + 2'd1 + 2'(i);
      rr_pick = valid[idx] ? idx : rr_pick;
    end
  endfunction

  assign winner_s = rr_pick(grant_r, req_valid);

  // Next-state logic; a watchdog expiry overrides any transmitter handshake.
  always_comb begin
    state_nxt_s = state_r;
    grant_go_s  = 1'b0;
    tmo_hit_s   = ((state_r == LAUNCH) || (state_r == WAIT_DONE)) &&
                  (wdog_r == TMO_CYCLES - 16'd1);
    case (state_r)
      IDLE: begin
        if (armed_r && enable && (req_valid != 4'b0000)) begin
          state_nxt_s = LAUNCH;
          grant_go_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LAUNCH: begin
        if (tmo_hit_s) begin
          state_nxt_s = GAP;
        end else if (tx_active) begin
          state_nxt_s = WAIT_DONE;
        end else begin
          state_nxt_s = LAUNCH;
        end
      end
      WAIT_DONE: begin
        if (tmo_hit_s || tx_done || (tx_active_d_r && !tx_active)) begin
          state_nxt_s = GAP;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      GAP: begin
        if (!tx_done && !tx_active) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, post-reset arming flag and transmitter-activity history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      armed_r       <= 1'b0;
      tx_active_d_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      armed_r       <= 1'b1;
      tx_active_d_r <= tx_active;
    end
  end

  // Grant capture, accept pulse and frame watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_r     <= 2'd3;
      tx_data_r   <= 8'h00;
      req_ready_r <= 4'b0000;
      wdog_r      <= 16'd0;
    end else if (grant_go_s) begin
      grant_r     <= winner_s;
      tx_data_r   <= req_data[{winner_s, 3'b000} +: 8];
      req_ready_r <= 4'b0001 << winner_s;
      wdog_r      <= 16'd0;
    end else begin
      req_ready_r <= 4'b0000;
      if ((state_r == LAUNCH) || (state_r == WAIT_DONE)) begin
        wdog_r <= wdog_r + 16'd1;
      end else begin
        wdog_r <= wdog_r;
      end
    end
  end

  // Registered status outputs; the error flag gives a new timeout priority over err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_start_r    <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      tx_start_r <= (state_nxt_s == LAUNCH);
      busy_r     <= (state_nxt_s != IDLE);
      if (tmo_hit_s) begin
        timeout_err_r <= 1'b1;
      end else if (err_clr) begin
        timeout_err_r <= 1'b0;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign tx_start    = tx_start_r;
  assign tx_ready    = tx_start_r;
  assign tx_data     = tx_data_r;
  assign grant       = grant_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TMO_CYCLES, default 16'd65535, is the watchdog limit in clk cycles for one frame (LAUNCH plus WAIT_DONE).
REQ-002 clk  in  1  system clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low; rst==0 forces reset state immediately.
REQ-004 enable  in  1  1 allows new grants; 0 stops new grants but lets the frame in flight finish.
REQ-005 req_valid  in  4  per-channel request; channel i has a byte pending.
REQ-006 req_data  in  32  per-channel byte; channel i occupies [8i+7:8i].
REQ-007 req_ready  out  4  one-hot, single-cycle accept pulse to the granted channel.
REQ-008 tx_start  out  1  start request to transmitter.
REQ-009 tx_ready  out  1  data-ready flag to transmitter; equal to tx_start.
REQ-010 tx_data  out  8  byte to transmitter; stable from accept until return to IDLE.
REQ-011 tx_active  in  1  transmitter is_active.
REQ-012 tx_done  in  1  transmitter frame-complete flag; a level may last several clk cycles.
REQ-013 grant  out  2  index of the last accepted channel.
REQ-014 busy  out  1  1 in any state other than IDLE.
REQ-015 timeout_err  out  1  sticky watchdog flag.
REQ-016 err_clr  in  1  synchronous clear of timeout_err.

Function
REQ-017 States SHALL be IDLE, LAUNCH, WAIT_DONE and GAP, with one-hot encoding.
REQ-018 IDLE SHALL go to LAUNCH when enable==1 and any req_valid is set; otherwise it SHALL hold.
- On that edge: pick the winner, load tx_data from the winner's byte, load grant, and assert req_ready[winner] for exactly the next cycle.
REQ-019 Arbitration SHALL be round-robin: search starts at (grant+1) mod 4 and ascends with wrap; the first set req_valid wins.
REQ-020 LAUNCH SHALL drive tx_start=tx_ready=1.
- On tx_active==1, go to WAIT_DONE.
- tx_start SHALL be held across multiple clk cycles because the transmitter samples only on baud ticks.
REQ-021 WAIT_DONE SHALL drive tx_start=0.
- Go to GAP on the first cycle with tx_done==1 or with tx_active falling 1->0, whichever comes first.
REQ-022 GAP SHALL last one cycle and then go to IDLE only when tx_done==0 and tx_active==0; otherwise it SHALL hold, so one frame is never counted twice.
REQ-023 Watchdog: a 16-bit counter SHALL clear on entering LAUNCH and increment each cycle in LAUNCH or WAIT_DONE.
- When it reaches TMO_CYCLES: set timeout_err, go to GAP, drop tx_start.
- The accepted byte is then lost and is not retried.
REQ-024 err_clr==1 SHALL clear timeout_err; if a timeout and err_clr occur in the same cycle, the timeout SHALL win.
REQ-025 enable falling mid-frame SHALL NOT abort the frame; the block then stays in IDLE with req_ready=0.
REQ-026 A req_valid that deasserts before it is granted SHALL be dropped silently; after its req_ready pulse, a channel may change req_data freely.
REQ-027 Only one frame SHALL be outstanding at a time; at most one req_ready bit is ever set, and only in the cycle after an IDLE->LAUNCH transition.

Reset
REQ-028 With rst==0, the block SHALL be in IDLE with these outputs:
- grant=2'd3, so channel 0 has first priority.
- tx_data=8'h00, tx_start=0, tx_ready=0, req_ready=4'b0000.
- busy=0, timeout_err=0, watchdog=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no req_ready or error side effects, and tx_start SHALL drop asynchronously.
REQ-030 After rst rises, the first grant SHALL occur no earlier than the second posedge clk.

Verification
REQ-031 Single request: req_valid=4'b0100, ch2=8'hA5 -> req_ready=4'b0100 for 1 cycle, tx_data=8'hA5, grant=2, tx_start held until tx_active, busy back to 0 after tx_done.
REQ-032 Round-robin: req_valid=4'b1111 held for 5 frames -> grant sequence 0,1,2,3,0, each channel's req_ready pulsing once in turn.
REQ-033 Long tx_done: tx_done held 20 cycles -> exactly one GAP->IDLE transition and exactly one req_ready pulse per frame.
REQ-034 Watchdog: TMO_CYCLES=100, tx_active tied 0 -> timeout_err=1 at cycle 100 after LAUNCH, IDLE follows; err_clr pulse -> timeout_err=0.
REQ-035 enable=0 during WAIT_DONE with req_valid=4'b0011 -> current frame completes and no new grant follows; enable=1 -> next grant is channel (grant+1) with a set req_valid.
REQ-036 rst=0 asserted in LAUNCH -> tx_start=0 the same cycle, all outputs at reset values; after release, req_valid=4'b1000 -> grant=3.
